// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard/stall interlock: FSM state encoding,
// the "no special register" selector value and the NOP-insertion control
// bundle that is also consumed by the forwarding logic.
package hazard_stall_unit_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEMWAIT = 1'b1
  } hs_state_e;

  // Special-register selector value meaning "no special register".
  localparam int SPEC_NONE = 0;

  // Hold/bubble controls for the pipeline registers, MSB first.
  typedef struct packed {
    logic pc_hold;
    logic ifid_hold;
    logic ifid_bubble;
    logic idex_hold;
    logic idex_bubble;
    logic exmem_hold;
    logic memwb_bubble;
  } nop_ctrl_t;

  localparam nop_ctrl_t CTRL_NONE   = nop_ctrl_t'(7'b000_0000);
  // Load-use: keep PC and IF/ID, push a NOP into EX.
  localparam nop_ctrl_t CTRL_LU     = nop_ctrl_t'(7'b110_0100);
  // Memory wait: freeze everything up to EX/MEM, drain a NOP into WB.
  localparam nop_ctrl_t CTRL_FREEZE = nop_ctrl_t'(7'b110_1011);
  // Fetch slot lost to a data access on the shared RAM.
  localparam nop_ctrl_t CTRL_FETCH  = nop_ctrl_t'(7'b101_0000);

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side signal bundle for the hazard/stall unit.
// Handshake: memAccess_a_EXMEM is the request (valid) from the MEM stage and
// memReady is the RAM completion (ready); a RAM access completes on a cycle
// where both are high, and a cycle with memAccess_a_EXMEM=1, memReady=0 is a
// wait state. All other fields are level signals valid every cycle.
interface hazard_stall_unit_if #(
  parameter int REG_ID_W = 3,
  parameter int SPEC_W   = 2,
  parameter int CNT_W    = 16
);
  logic [REG_ID_W-1:0] Rx_a_IFID;
  logic [REG_ID_W-1:0] Ry_a_IFID;
  logic                readRx_a_IFID;
  logic                readRy_a_IFID;
  logic [SPEC_W-1:0]   readSpecReg_a_IFID;
  logic                regWrite_a_IDEX;
  logic                memRead_a_IDEX;
  logic [REG_ID_W-1:0] registerToWriteId_a_IDEX;
  logic [SPEC_W-1:0]   writeSpecReg_a_IDEX;
  logic                memAccess_a_EXMEM;
  logic                memReady;
  logic                pcHold;
  logic                ifidHold;
  logic                ifidBubble;
  logic                idexHold;
  logic                idexBubble;
  logic                exmemHold;
  logic                memwbBubble;
  logic                memTimeout;
  logic [CNT_W-1:0]    stallCount;

  // Pipeline side: supplies stage information, receives controls.
  modport master (
    output Rx_a_IFID, Ry_a_IFID, readRx_a_IFID, readRy_a_IFID,
           readSpecReg_a_IFID, regWrite_a_IDEX, memRead_a_IDEX,
           registerToWriteId_a_IDEX, writeSpecReg_a_IDEX,
           memAccess_a_EXMEM, memReady,
    input  pcHold, ifidHold, ifidBubble, idexHold, idexBubble,
           exmemHold, memwbBubble, memTimeout, stallCount
  );

  // Interlock side.
  modport slave (
    input  Rx_a_IFID, Ry_a_IFID, readRx_a_IFID, readRy_a_IFID,
           readSpecReg_a_IFID, regWrite_a_IDEX, memRead_a_IDEX,
           registerToWriteId_a_IDEX, writeSpecReg_a_IDEX,
           memAccess_a_EXMEM, memReady,
    output pcHold, ifidHold, ifidBubble, idexHold, idexBubble,
           exmemHold, memwbBubble, memTimeout, stallCount
  );
endinterface

// File: rtl/hazard_stall_unit_compare.sv
// Combinational producer/consumer register comparator. Reports whether a
// register-writing producer targets a register (general or special) that
// the consumer reads. Kept free of load-specific terms so it can also be
// used for branch-hazard checks.
module hazard_compare
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_ID_W = 3,
  parameter int SPEC_W   = 2
) (
  input  logic [REG_ID_W-1:0] i_rx,
  input  logic [REG_ID_W-1:0] i_ry,
  input  logic                i_read_rx,
  input  logic                i_read_ry,
  input  logic [SPEC_W-1:0]   i_read_spec,
  input  logic                i_reg_write,
  input  logic [REG_ID_W-1:0] i_dest,
  input  logic [SPEC_W-1:0]   i_write_spec,
  output logic                o_match
);

  logic w_rx_match;
  logic w_ry_match;
  logic w_spec_match;

  // A special-register match stands on its own; no index match is needed.
  always_comb begin
    w_rx_match   = i_read_rx && (i_rx == i_dest);
    w_ry_match   = i_read_ry && (i_ry == i_dest);
    w_spec_match = (i_write_spec != SPEC_W'(SPEC_NONE)) &&
                   (i_read_spec == i_write_spec);
    o_match      = i_reg_write && (w_rx_match || w_ry_match || w_spec_match);
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline interlock: stalls/bubbles for load-use hazards, RAM wait states
// and shared-RAM fetch conflicts. Controls are Mealy outputs so they act in
// the cycle the condition is seen. A sticky timeout flag catches a RAM that
// never answers, and a saturating counter records PC-stall cycles.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_ID_W    = 3,
  parameter int SPEC_W      = 2,
  parameter bit SHARED_IMEM = 1'b1,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  hazard_stall_unit_if.slave     hs,
  output hs_state_e              o_state
);

  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  hs_state_e         r_state;
  hs_state_e         w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              r_timeout;
  logic              w_timeout_set;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_lu;
  logic              w_reg_match;
  logic              w_mw;
  nop_ctrl_t         w_ctrl;
  nop_ctrl_t         w_out;

  hazard_compare #(
    .REG_ID_W (REG_ID_W),
    .SPEC_W   (SPEC_W)
  ) u_compare (
    .i_rx         (hs.Rx_a_IFID),
    .i_ry         (hs.Ry_a_IFID),
    .i_read_rx    (hs.readRx_a_IFID),
    .i_read_ry    (hs.readRy_a_IFID),
    .i_read_spec  (hs.readSpecReg_a_IFID),
    .i_reg_write  (hs.regWrite_a_IDEX),
    .i_dest       (hs.registerToWriteId_a_IDEX),
    .i_write_spec (hs.writeSpecReg_a_IDEX),
    .o_match      (w_reg_match)
  );

  // Hazard conditions: load-use needs a load in EX; wait is an unanswered access.
  always_comb begin
    w_lu = hs.memRead_a_IDEX && w_reg_match;
    w_mw = hs.memAccess_a_EXMEM && !hs.memReady;
  end

  // Next state and Mealy controls. Priority: memory wait, then load-use,
  // then fetch conflict. On the cycle the RAM answers, the held ID/EX pair
  // is re-checked for load-use before the fetch-conflict bubble applies.
  always_comb begin
    w_ctrl        = CTRL_NONE;
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_timeout_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mw) begin
          w_ctrl      = CTRL_FREEZE;
          w_state_nxt = ST_MEMWAIT;
          w_wait_nxt  = WAIT_W'(1);
        end else if (w_lu) begin
          w_ctrl = CTRL_LU;
        end else if (SHARED_IMEM && hs.memAccess_a_EXMEM) begin
          w_ctrl = CTRL_FETCH;
        end
      end
      ST_MEMWAIT: begin
        if (hs.memReady) begin
          w_state_nxt = ST_IDLE;
          w_wait_nxt  = '0;
          if (w_lu) begin
            w_ctrl = CTRL_LU;
          end else if (SHARED_IMEM) begin
            w_ctrl = CTRL_FETCH;
          end
        end else if (r_wait_cnt == WAIT_W'(TIMEOUT)) begin
          w_timeout_set = 1'b1;
          w_state_nxt   = ST_IDLE;
          w_wait_nxt    = '0;
        end else begin
          w_ctrl     = CTRL_FREEZE;
          w_wait_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_wait_nxt  = '0;
      end
    endcase
    // Controls are forced quiet while reset is asserted.
    w_out = rst ? w_ctrl : CTRL_NONE;
  end

  // FSM state, wait-cycle counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_timeout_set) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_out.pc_hold && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign hs.pcHold      = w_out.pc_hold;
  assign hs.ifidHold    = w_out.ifid_hold;
  assign hs.ifidBubble  = w_out.ifid_bubble;
  assign hs.idexHold    = w_out.idex_hold;
  assign hs.idexBubble  = w_out.idex_bubble;
  assign hs.exmemHold   = w_out.exmem_hold;
  assign hs.memwbBubble = w_out.memwb_bubble;
  assign hs.memTimeout  = r_timeout;
  assign hs.stallCount  = r_stall_cnt;
  assign o_state        = r_state;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit. The driver applies one vector per
// cycle just after the rising edge and queues the hand-computed response;
// the monitor samples on the falling edge and compares against the queue.
// Expected word: {pc,ifidH,ifidB,idexH,idexB,exmemH,memwbB, timeout, cnt[3:0], state}.
module tb_hazard_stall_unit;
  import hazard_stall_unit_pkg::*;

  localparam int EXP_W = 13;
  localparam logic [6:0] P_NONE = 7'b000_0000;
  localparam logic [6:0] P_LU   = 7'b110_0100;
  localparam logic [6:0] P_FRZ  = 7'b110_1011;
  localparam logic [6:0] P_FET  = 7'b101_0000;

  logic      clk;
  logic      rst;
  hs_state_e dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  int               id_q[$];
  int               n_checks;
  int               n_pass;
  int               step_no;

  hazard_stall_unit_if #(.REG_ID_W(3), .SPEC_W(2), .CNT_W(4)) hs ();

  hazard_stall_unit #(
    .REG_ID_W    (3),
    .SPEC_W      (2),
    .SHARED_IMEM (1'b1),
    .TIMEOUT     (4),
    .CNT_W       (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .hs      (hs.slave),
    .o_state (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: apply one vector and queue its expected response
  task automatic step(
    input logic       rst_v,
    input logic [2:0] rx, input logic [2:0] ry,
    input logic       rdx, input logic rdy, input logic [1:0] rspec,
    input logic       regw, input logic memrd, input logic [2:0] dest,
    input logic [1:0] wspec, input logic macc, input logic mrdy,
    input logic [6:0] e_ctrl, input logic e_tout, input logic [3:0] e_cnt,
    input logic       e_state
  );
    @(posedge clk);
    #1;
    rst                         = rst_v;
    hs.Rx_a_IFID                = rx;
    hs.Ry_a_IFID                = ry;
    hs.readRx_a_IFID            = rdx;
    hs.readRy_a_IFID            = rdy;
    hs.readSpecReg_a_IFID       = rspec;
    hs.regWrite_a_IDEX          = regw;
    hs.memRead_a_IDEX           = memrd;
    hs.registerToWriteId_a_IDEX = dest;
    hs.writeSpecReg_a_IDEX      = wspec;
    hs.memAccess_a_EXMEM        = macc;
    hs.memReady                 = mrdy;
    step_no++;
    exp_q.push_back({e_ctrl, e_tout, e_cnt, e_state});
    id_q.push_back(step_no);
  endtask

  // Monitor / scoreboard: compare each queued expectation at the falling edge
  always @(negedge clk) begin
    logic [EXP_W-1:0] act;
    logic [EXP_W-1:0] exp_v;
    int               sid;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      sid   = id_q.pop_front();
      act   = {hs.pcHold, hs.ifidHold, hs.ifidBubble, hs.idexHold,
               hs.idexBubble, hs.exmemHold, hs.memwbBubble, hs.memTimeout,
               hs.stallCount, dbg_state == ST_MEMWAIT};
      n_checks++;
      if (act === exp_v) begin
        n_pass++;
      end else begin
        $display("FAIL step%0d: ctrl got %b want %b, timeout got %b want %b, cnt got %0d want %0d, state got %b want %b",
                 sid, act[12:6], exp_v[12:6], act[5], exp_v[5],
                 act[4:1], exp_v[4:1], act[0], exp_v[0]);
      end
    end
  end

  // Stimulus: directed vectors with hand-computed responses
  initial begin
    n_checks = 0;
    n_pass   = 0;
    step_no  = 0;
    rst = 1'b0;
    hs.Rx_a_IFID = '0; hs.Ry_a_IFID = '0; hs.readRx_a_IFID = 1'b0;
    hs.readRy_a_IFID = 1'b0; hs.readSpecReg_a_IFID = '0;
    hs.regWrite_a_IDEX = 1'b0; hs.memRead_a_IDEX = 1'b0;
    hs.registerToWriteId_a_IDEX = '0; hs.writeSpecReg_a_IDEX = '0;
    hs.memAccess_a_EXMEM = 1'b0; hs.memReady = 1'b0;

    // reset state, then release
    step(0, 0,0,0,0,0, 0,0,0,0, 0,0, P_NONE,0,0,0);
    step(1, 0,0,0,0,0, 0,0,0,0, 0,0, P_NONE,0,0,0);
    // load R3, ID reads Rx=3: one-cycle stall
    step(1, 3,0,1,0,0, 1,1,3,0, 0,0, P_LU,  0,0,0);
    step(1, 3,0,1,0,0, 0,0,0,0, 0,0, P_NONE,0,1,0);
    // special-register 2 match with different index; then spec 1 no match
    step(1, 5,0,1,0,2, 1,1,3,2, 0,0, P_LU,  0,1,0);
    step(1, 5,0,1,0,1, 1,1,3,2, 0,0, P_NONE,0,2,0);
    // memRead without regWrite never stalls
    step(1, 3,0,1,0,0, 0,1,3,0, 0,0, P_NONE,0,2,0);
    // match through Ry; then indices equal but no read enables
    step(1, 0,3,0,1,0, 1,1,3,0, 0,0, P_LU,  0,2,0);
    step(1, 3,3,0,0,0, 1,1,3,0, 0,0, P_NONE,0,3,0);
    // memory wait 3 cycles then ready: freeze x3, release with fetch bubble
    step(1, 0,0,0,0,0, 0,0,0,0, 1,0, P_FRZ, 0,3,0);
    step(1, 0,0,0,0,0, 0,0,0,0, 1,0, P_FRZ, 0,4,1);
    step(1, 0,0,0,0,0, 0,0,0,0, 1,0, P_FRZ, 0,5,1);
    step(1, 0,0,0,0,0, 0,0,0,0, 1,1, P_FET, 0,6,1);
    // immediate data access in IDLE: fetch conflict
    step(1, 0,0,0,0,0, 0,0,0,0, 1,1, P_FET, 0,7,0);
    step(1, 0,0,0,0,0, 0,0,0,0, 0,0, P_NONE,0,8,0);
    // RAM never answers: timeout after 4 wait cycles, flag sticky
    step(1, 0,0,0,0,0, 0,0,0,0, 1,0, P_FRZ, 0,8,0);
    step(1, 0,0,0,0,0, 0,0,0,0, 1,0, P_FRZ, 0,9,1);
    step(1, 0,0,0,0,0, 0,0,0,0, 1,0, P_FRZ, 0,10,1);
    step(1, 0,0,0,0,0, 0,0,0,0, 1,0, P_FRZ, 0,11,1);
    step(1, 0,0,0,0,0, 0,0,0,0, 1,0, P_NONE,0,12,1);
    step(1, 0,0,0,0,0, 0,0,0,0, 0,0, P_NONE,1,12,0);
    step(1, 0,0,0,0,0, 0,0,0,0, 0,0, P_NONE,1,12,0);
    // load-use coincident with memory wait: freeze only, LU on release
    step(1, 3,0,1,0,0, 1,1,3,0, 1,0, P_FRZ, 1,12,0);
    step(1, 3,0,1,0,0, 1,1,3,0, 1,0, P_FRZ, 1,13,1);
    step(1, 3,0,1,0,0, 1,1,3,0, 1,1, P_LU,  1,14,1);
    step(1, 3,0,1,0,0, 0,0,0,0, 0,0, P_NONE,1,15,0);
    // counter saturated at 15; reset mid-MEMWAIT clears everything
    step(1, 0,0,0,0,0, 0,0,0,0, 1,0, P_FRZ, 1,15,0);
    step(1, 0,0,0,0,0, 0,0,0,0, 1,0, P_FRZ, 1,15,1);
    step(0, 0,0,0,0,0, 0,0,0,0, 1,0, P_NONE,0,0,0);
    step(1, 0,0,0,0,0, 0,0,0,0, 0,0, P_NONE,0,0,0);
    // counting restarts from zero after reset
    step(1, 3,0,1,0,0, 1,1,3,0, 0,0, P_LU,  0,0,0);
    step(1, 0,0,0,0,0, 0,0,0,0, 0,0, P_NONE,0,1,0);

    // drain the scoreboard with a bounded wait
    @(negedge clk);
    #1;
    for (int k = 0; k < 4 && exp_q.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Interlock controller paired with the forwarding logic. The forwarding logic resolves hazards by bypassing values; this block resolves the hazards that bypassing cannot cover, by holding and bubbling pipeline registers. It covers three cases: load-use hazards, wait states on the shared RAM bus, and instruction-fetch conflicts when data and instructions share one RAM. It sits beside the ID/EX and EX/MEM registers and drives the hold/bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
REG_ID_W, 3, width of general register index
SPEC_W, 2, width of special-register selector (0 = none)
SHARED_IMEM, 1, 1 = instruction fetch shares RAM with data access
TIMEOUT, 255, maximum memory wait cycles before error
CNT_W, 16, width of stall-cycle performance counter

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous reset, active-low
Rx_a_IFID  in  REG_ID_W  source register X of instruction in ID
Ry_a_IFID  in  REG_ID_W  source register Y of instruction in ID
readRx_a_IFID  in  1  ID instruction reads Rx
readRy_a_IFID  in  1  ID instruction reads Ry
readSpecReg_a_IFID  in  SPEC_W  special register read by ID (0 = none)
regWrite_a_IDEX  in  1  EX instruction writes a register
memRead_a_IDEX  in  1  EX instruction is a load
registerToWriteId_a_IDEX  in  REG_ID_W  EX destination register
writeSpecReg_a_IDEX  in  SPEC_W  special register written by EX (0 = none)
memAccess_a_EXMEM  in  1  MEM-stage instruction uses RAM (load or store)
memReady  in  1  RAM controller: access completes this cycle
pcHold  out  1  PC keeps its value
ifidHold  out  1  IF/ID register keeps its value
ifidBubble  out  1  IF/ID loads a NOP
idexHold  out  1  ID/EX keeps its value
idexBubble  out  1  ID/EX loads a NOP
exmemHold  out  1  EX/MEM keeps its value
memwbBubble  out  1  MEM/WB loads a NOP
memTimeout  out  1  sticky error flag
stallCount  out  CNT_W  saturating count of cycles with pcHold=1

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, waitCnt=0, memTimeout=0, stallCount=0. All hold/bubble outputs read 0 while in reset.
- FSM states: IDLE, MEMWAIT. Hold/bubble outputs are combinational from the state and the current inputs (Mealy), so they apply in the same cycle.
- Load-use hazard (LU) fires when memRead_a_IDEX=1, regWrite_a_IDEX=1, and either of:
  - (readRx=1 and Rx==dest) or (readRy=1 and Ry==dest);
  - writeSpecReg_a_IDEX!=0 and readSpecReg_a_IFID==writeSpecReg_a_IDEX.
- A special-register match does not require an index match. memRead=1 with regWrite=0 never causes a hazard.
- Memory wait (MW) is memAccess_a_EXMEM=1 and memReady=0.
- IDLE:
  - MW: assert pcHold, ifidHold, idexHold, exmemHold, memwbBubble; go to MEMWAIT; waitCnt<=1.
  - else LU: assert pcHold, ifidHold, idexBubble for exactly this cycle; stay in IDLE. The load advances, so LU clears next cycle and forwarding covers the rest.
  - else SHARED_IMEM=1 and memAccess_a_EXMEM=1 (memReady=1): assert pcHold, ifidBubble (fetch lost to data access).
  - else all outputs 0.
- MEMWAIT:
  - Hold set as for MW each cycle.
  - memReady=1: release holds in that same cycle; go to IDLE; waitCnt<=0. If SHARED_IMEM=1, that cycle also asserts pcHold and ifidBubble.
  - waitCnt==TIMEOUT with memReady=0: set memTimeout=1 (sticky until reset), release holds, go to IDLE.
  - Otherwise waitCnt++.
- Priority: MW/MEMWAIT over LU over fetch conflict. An LU coincident with MW is suppressed; it is re-evaluated once the freeze ends because ID/EX was held.
- stallCount increments on every cycle with pcHold=1 and saturates at all-ones.
- No output ever asserts both hold and bubble on the same register.

Decomposition:
- Shared package: state encoding (IDLE, MEMWAIT), SPEC_NONE=0, and the NOP-insertion control bundle struct shared with the forwarding logic.
- One natural sub-module: hazard_compare, the combinational LU comparator (register and special-register match). It can be reused by a branch-hazard checker later.

Test Plan:
- Load R3 in EX (memRead=1, regWrite=1, dest=3), ID reads Rx=3 -> one cycle of pcHold=ifidHold=idexBubble=1, then 0; stallCount=1.
- Load writing special register 2, ID readSpecReg=2 with Rx=5, dest=3 -> one-cycle LU stall. Same load with readSpecReg=1 -> no stall.
- memAccess=1, memReady low for 3 cycles then high -> pcHold/ifidHold/idexHold/exmemHold/memwbBubble high for 3 cycles. The release cycle asserts pcHold with ifidBubble only (SHARED_IMEM=1); stallCount=4.
- memReady held low with TIMEOUT=4 -> memTimeout=1 after 4 wait cycles, FSM in IDLE, flag persists until rst=0.
- LU and MW in the same cycle -> only the MW freeze pattern (idexBubble=0), then LU bubble appears after memReady.
- Assert rst=0 mid-MEMWAIT -> all outputs 0 immediately, state=IDLE, stallCount=0.
